// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencer:
//                FSM state encoding, default halt opcode, stage-control
//                bundle and a saturating increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Sequencer states (2-bit encoding fixed so debug taps stay stable)
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Opcode that stops the machine when it reaches ID
    localparam logic [3:0] C_HALT_OPC = 4'hF;

    // drain_cnt value at which EX, MEM and WB hold only bubbles
    localparam logic [1:0] C_DRAIN_LAST = 2'd2;

    // One pipeline register's write-enable / synchronous-clear pair
    typedef struct packed {
        logic wr;
        logic clr;
    } stage_ctrl_t;

    // Common stage-control combinations
    localparam stage_ctrl_t C_STG_PASS  = '{wr: 1'b1, clr: 1'b0};
    localparam stage_ctrl_t C_STG_HOLD  = '{wr: 1'b0, clr: 1'b0};
    localparam stage_ctrl_t C_STG_FLUSH = '{wr: 1'b1, clr: 1'b1};
    localparam stage_ctrl_t C_STG_ZAP   = '{wr: 1'b0, clr: 1'b1};

    // 16-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the pipeline datapath (master) and the
//                hazard/sequencing controller (slave). Optional performance
//                counters appear when PIPE_HAZARD_CTRL_PERF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

    // Datapath -> controller
    logic [3:0]  IFIDopcode;
    logic [3:0]  IFIDrs;
    logic [3:0]  IFIDrt;
    logic        IFIDuses_rt;
    logic        IDEXmemtoReg;
    logic [3:0]  IDEXrd;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_rdy;
    logic        resume;

    // Controller -> datapath
    logic        wr_PC;
    logic        wr_IFID;
    logic        wr_IDEX;
    logic        wr_EXMEM;
    logic        wr_MEMWB;
    logic        IFIDclear;
    logic        IDEXclear;
    logic        EXMEMclear;
    logic        MEMWBclear;
    logic        pc_sel;
    logic        halted;
    logic        mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    modport master (
        output IFIDopcode, IFIDrs, IFIDrt, IFIDuses_rt, IDEXmemtoReg, IDEXrd,
               branch_taken, dmem_req, dmem_rdy, resume,
        input  wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB,
               IFIDclear, IDEXclear, EXMEMclear, MEMWBclear,
               pc_sel, halted, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  IFIDopcode, IFIDrs, IFIDrt, IFIDuses_rt, IDEXmemtoReg, IDEXrd,
               branch_taken, dmem_req, dmem_rdy, resume,
        output wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB,
               IFIDclear, IDEXclear, EXMEMclear, MEMWBclear,
               pc_sel, halted, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_hazard_detect
//  Description : Combinational load-use comparator. Flags when the load in
//                EX writes a register that the instruction in ID reads.
//                Register r0 is hard-wired zero and never creates a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl_hazard_detect (
    input  wire logic       i_idex_memtoreg,
    input  wire logic [3:0] i_idex_rd,
    input  wire logic [3:0] i_ifid_rs,
    input  wire logic [3:0] i_ifid_rt,
    input  wire logic       i_ifid_uses_rt,
    output logic            o_hazard
);

    logic w_rd_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    assign w_rd_nonzero = (i_idex_rd != 4'd0);
    assign w_rs_match   = (i_idex_rd == i_ifid_rs);
    assign w_rt_match   = i_ifid_uses_rt && (i_idex_rd == i_ifid_rt);

    assign o_hazard = i_idex_memtoreg && w_rd_nonzero && (w_rs_match || w_rt_match);

endmodule : pipe_hazard_ctrl_hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central sequencer for the 4-stage-register 16-bit pipeline.
//                Drives all stage write enables / clears, PC write and PC
//                select. Handles load-use stalls, taken-branch flushes,
//                data-memory wait freezes with timeout and halt/drain/resume.
//                State and counters are registered; control outputs are
//                combinational from state and current inputs.
//                Optional macro PIPE_HAZARD_CTRL_PERF_EN adds saturating
//                stall_cnt / flush_cnt performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [3:0]      HALT_OPC    = C_HALT_OPC,
    parameter int              TO_W        = 8,
    parameter logic [TO_W-1:0] MEM_TIMEOUT = TO_W'(255)
) (
    input  wire logic          clk,
    input  wire logic          reset,     // synchronous, active-low
    pipe_hazard_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          r_ret_state;   // where MEM_WAIT returns to
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_drain_cnt;
    logic            r_mem_err;

    // ------------------------------------------------------------------
    // Decision wires
    // ------------------------------------------------------------------
    logic w_hazard;
    logic w_mem_stall;
    logic w_can_freeze;
    logic w_freeze_enter;
    logic w_wait_hold;
    logic w_is_halt_op;
    logic w_branch;
    logic w_halt_det;
    logic w_load_use;
    logic w_resume;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_idex_memtoreg (bus.IDEXmemtoReg),
        .i_idex_rd       (bus.IDEXrd),
        .i_ifid_rs       (bus.IFIDrs),
        .i_ifid_rt       (bus.IFIDrt),
        .i_ifid_uses_rt  (bus.IFIDuses_rt),
        .o_hazard        (w_hazard)
    );

    assign w_mem_stall    = bus.dmem_req && !bus.dmem_rdy;
    assign w_can_freeze   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_freeze_enter = w_can_freeze && w_mem_stall;
    assign w_wait_hold    = (r_state == ST_MEM_WAIT) && !bus.dmem_rdy;
    assign w_is_halt_op   = (bus.IFIDopcode == HALT_OPC);

    // Priority chain in RUN: freeze > branch > halt > load-use.
    // A taken branch squashes whatever sits in ID, including a halt.
    assign w_branch   = (r_state == ST_RUN) && !w_mem_stall && bus.branch_taken;
    assign w_halt_det = (r_state == ST_RUN) && !w_mem_stall && !bus.branch_taken
                        && w_is_halt_op;
    assign w_load_use = (r_state == ST_RUN) && !w_mem_stall && !bus.branch_taken
                        && !w_is_halt_op && w_hazard;
    assign w_resume   = (r_state == ST_HALT) && bus.resume;

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    logic        w_pc_wr;
    logic        w_pc_sel;
    logic        w_halted;
    stage_ctrl_t w_ifid;
    stage_ctrl_t w_idex;
    stage_ctrl_t w_exmem;
    stage_ctrl_t w_memwb;

    // Decode current state and inputs into stage enables/clears
    always_comb begin
        w_pc_wr  = 1'b1;
        w_pc_sel = 1'b0;
        w_halted = 1'b0;
        w_ifid   = C_STG_PASS;
        w_idex   = C_STG_PASS;
        w_exmem  = C_STG_PASS;
        w_memwb  = C_STG_PASS;

        if (!reset) begin
            // Hold everything and scrub every stage while reset is asserted
            w_pc_wr = 1'b0;
            w_ifid  = C_STG_ZAP;
            w_idex  = C_STG_ZAP;
            w_exmem = C_STG_ZAP;
            w_memwb = C_STG_ZAP;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze_enter) begin
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                        w_idex  = C_STG_HOLD;
                        w_exmem = C_STG_HOLD;
                        w_memwb = C_STG_ZAP;
                    end else if (w_branch) begin
                        w_pc_sel = 1'b1;
                        w_ifid   = C_STG_FLUSH;
                        w_idex   = C_STG_FLUSH;
                    end else if (w_halt_det || w_load_use) begin
                        // Both hold PC/IFID and inject a bubble into ID/EX
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                        w_idex  = C_STG_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    if (w_freeze_enter) begin
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                        w_idex  = C_STG_HOLD;
                        w_exmem = C_STG_HOLD;
                        w_memwb = C_STG_ZAP;
                    end else begin
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                        w_idex  = C_STG_FLUSH;
                    end
                end
                ST_MEM_WAIT: begin
                    // On dmem_rdy the RUN defaults apply for this one cycle
                    if (!bus.dmem_rdy) begin
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                        w_idex  = C_STG_HOLD;
                        w_exmem = C_STG_HOLD;
                        w_memwb = C_STG_ZAP;
                    end
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                    w_idex   = C_STG_HOLD;
                    w_exmem  = C_STG_HOLD;
                    w_memwb  = C_STG_HOLD;
                    if (w_resume) begin
                        // Step past the halt that is still sitting in IF/ID
                        w_pc_wr = 1'b1;
                        w_ifid  = '{wr: 1'b0, clr: 1'b1};
                    end else begin
                        w_pc_wr = 1'b0;
                        w_ifid  = C_STG_HOLD;
                    end
                end
                default: begin
                    w_pc_wr = 1'b0;
                    w_ifid  = C_STG_HOLD;
                    w_idex  = C_STG_HOLD;
                    w_exmem = C_STG_HOLD;
                    w_memwb = C_STG_HOLD;
                end
            endcase
        end
    end

    assign bus.wr_PC      = w_pc_wr;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.halted     = w_halted;
    assign bus.wr_IFID    = w_ifid.wr;
    assign bus.IFIDclear  = w_ifid.clr;
    assign bus.wr_IDEX    = w_idex.wr;
    assign bus.IDEXclear  = w_idex.clr;
    assign bus.wr_EXMEM   = w_exmem.wr;
    assign bus.EXMEMclear = w_exmem.clr;
    assign bus.wr_MEMWB   = w_memwb.wr;
    assign bus.MEMWBclear = w_memwb.clr;
    assign bus.mem_err    = r_mem_err;

    // ------------------------------------------------------------------
    // Sequencer FSM with wait-timeout and drain counters
    // ------------------------------------------------------------------
    // Advance state, counters and the sticky timeout flag each cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_to_cnt    <= '0;
            r_drain_cnt <= 2'd0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze_enter) begin
                        r_state     <= ST_MEM_WAIT;
                        r_ret_state <= ST_RUN;
                        r_to_cnt    <= TO_W'(1);
                    end else if (w_halt_det) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    // drain_cnt is frozen while a memory wait interrupts draining
                    if (w_freeze_enter) begin
                        r_state     <= ST_MEM_WAIT;
                        r_ret_state <= ST_DRAIN;
                        r_to_cnt    <= TO_W'(1);
                    end else if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_rdy) begin
                        r_state <= r_ret_state;
                    end else if (r_to_cnt == MEM_TIMEOUT) begin
                        r_state   <= ST_HALT;
                        r_mem_err <= 1'b1;
                    end else if (r_to_cnt != {TO_W{1'b1}}) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_HALT: begin
                    if (w_resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Count stall cycles (load-use or memory freeze) and branch flushes
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_load_use || w_freeze_enter || w_wait_hold) begin
                r_stall_cnt <= sat_inc16(r_stall_cnt);
            end
            if (w_branch) begin
                r_flush_cnt <= sat_inc16(r_flush_cnt);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl. Covers
//                reset, load-use, branch priority, memory wait and timeout,
//                halt/drain/resume and reset during wait/drain. Counter
//                checks are included when PIPE_HAZARD_CTRL_PERF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector order:
    // {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB,
    //  IFIDclear, IDEXclear, EXMEMclear, MEMWBclear, pc_sel, halted, mem_err}
    localparam logic [11:0] E_RST    = 12'b00000_1111_000;
    localparam logic [11:0] E_RST_ME = 12'b00000_1111_001;
    localparam logic [11:0] E_NORM   = 12'b11111_0000_000;
    localparam logic [11:0] E_NORMME = 12'b11111_0000_001;
    localparam logic [11:0] E_STALL  = 12'b00111_0100_000;
    localparam logic [11:0] E_BR     = 12'b11111_1100_100;
    localparam logic [11:0] E_FRZ    = 12'b00000_0001_000;
    localparam logic [11:0] E_HALT   = 12'b00000_0000_010;
    localparam logic [11:0] E_HALTME = 12'b00000_0000_011;
    localparam logic [11:0] E_RES    = 12'b10000_1000_010;
    localparam logic [11:0] E_RESME  = 12'b10000_1000_011;

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {bus.wr_PC, bus.wr_IFID, bus.wr_IDEX, bus.wr_EXMEM, bus.wr_MEMWB,
               bus.IFIDclear, bus.IDEXclear, bus.EXMEMclear, bus.MEMWBclear,
               bus.pc_sel, bus.halted, bus.mem_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check mid-cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input logic [11:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IFIDopcode   = 4'h0;
        bus.IFIDrs       = 4'h0;
        bus.IFIDrt       = 4'h0;
        bus.IFIDuses_rt  = 1'b0;
        bus.IDEXmemtoReg = 1'b0;
        bus.IDEXrd       = 4'h0;
        bus.branch_taken = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_rdy     = 1'b0;
        bus.resume       = 1'b0;
    endtask

    task automatic set_lu(input logic [3:0] rd, input logic [3:0] rs);
        bus.IDEXmemtoReg = 1'b1;
        bus.IDEXrd       = rd;
        bus.IFIDrs       = rs;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // ---- reset ----
        step("reset_hold", E_RST);
        reset = 1'b1;
        step("run_idle", E_NORM);

        // ---- load-use via rs, then the bubble clears it ----
        set_lu(4'h3, 4'h3);
        step("lu_rs", E_STALL);
        idle_inputs();
        step("lu_rs_after", E_NORM);

        // ---- load-use via rt ----
        set_lu(4'h5, 4'h0);
        bus.IFIDrt = 4'h5; bus.IFIDuses_rt = 1'b1;
        step("lu_rt", E_STALL);
        bus.IFIDuses_rt = 1'b0;
        step("lu_rt_unused", E_NORM);

        // ---- r0 never hazards; non-load never hazards ----
        set_lu(4'h0, 4'h0);
        step("lu_r0", E_NORM);
        set_lu(4'h3, 4'h3); bus.IDEXmemtoReg = 1'b0;
        step("no_load", E_NORM);

        // ---- branch beats load-use and halt ----
        set_lu(4'h3, 4'h3); bus.branch_taken = 1'b1;
        step("br_over_lu", E_BR);
        idle_inputs();
        bus.branch_taken = 1'b1; bus.IFIDopcode = 4'hF;
        step("br_over_halt", E_BR);
        idle_inputs();
        step("br_halt_squashed", E_NORM);

        // ---- memory wait: 5 low cycles, freeze beats branch ----
        bus.dmem_req = 1'b1; bus.dmem_rdy = 1'b0; bus.branch_taken = 1'b1;
        step("frz_enter", E_FRZ);
        bus.branch_taken = 1'b0;
        for (int i = 1; i < 5; i++) step("frz_wait", E_FRZ);
        bus.dmem_rdy = 1'b1;
        step("frz_rdy", E_NORM);
        idle_inputs();
        set_lu(4'h3, 4'h3);
        step("frz_back_in_run", E_STALL);
        idle_inputs();

        // ---- halt / drain / resume ----
        bus.IFIDopcode = 4'hF;
        step("halt_detect", E_STALL);
        step("drain0", E_STALL);
        step("drain1", E_STALL);
        step("drain2", E_STALL);
        step("halted", E_HALT);
        step("halted_hold", E_HALT);
        bus.resume = 1'b1;
        step("resume", E_RES);
        idle_inputs();
        step("after_resume", E_NORM);

        // ---- reset during MEM_WAIT ----
        bus.dmem_req = 1'b1;
        step("rmw_enter", E_FRZ);
        reset = 1'b0;
        step("rmw_reset", E_RST);
        reset = 1'b1; idle_inputs();
        step("rmw_run", E_NORM);
        set_lu(4'h3, 4'h3);
        step("rmw_lu", E_STALL);
        idle_inputs();

        // ---- reset during DRAIN ----
        bus.IFIDopcode = 4'hF;
        step("rdr_detect", E_STALL);
        reset = 1'b0;
        step("rdr_reset", E_RST);
        reset = 1'b1; idle_inputs();
        step("rdr_run", E_NORM);
        step("rdr_run2", E_NORM);

        // ---- memory timeout ----
        bus.dmem_req = 1'b1; bus.dmem_rdy = 1'b0;
        step("to_enter", E_FRZ);
        for (int i = 1; i <= 255; i++) step("to_wait", E_FRZ);
        step("to_halt", E_HALTME);
        bus.dmem_req = 1'b0; bus.resume = 1'b1;
        step("to_resume", E_RESME);
        idle_inputs();
        step("to_sticky", E_NORMME);
        reset = 1'b0;
        step("to_reset_cycle", E_RST_ME);
        step("to_reset_clr", E_RST);
        reset = 1'b1;
        step("to_run", E_NORM);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        // ---- performance counters ----
        reset = 1'b0;
        step("perf_rst", E_RST);
        reset = 1'b1;
        chk16("stall_cnt_rst", bus.stall_cnt, 16'd0);
        chk16("flush_cnt_rst", bus.flush_cnt, 16'd0);
        for (int i = 0; i < 3; i++) begin
            set_lu(4'h7, 4'h7);
            step("perf_lu", E_STALL);
            idle_inputs();
            step("perf_gap", E_NORM);
        end
        for (int i = 0; i < 2; i++) begin
            bus.branch_taken = 1'b1;
            step("perf_br", E_BR);
            idle_inputs();
        end
        @(negedge clk);
        chk16("stall_cnt", bus.stall_cnt, 16'd3);
        chk16("flush_cnt", bus.flush_cnt, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
